// File: rtl/pwm_pkg.sv
// Shared PWM types: speed code, capture FSM states.
// Used by the PWM generator and pwm_capture.
package pwm_pkg;

  typedef logic [2:0] speed_t;

  typedef enum logic [1:0] {
    IDLE,
    HIGH,
    LOW
  } cap_state_t;

  localparam speed_t SPEED_MAX = 3'd7;

endpackage

// File: rtl/pwm_edge_sync.sv
// PWM input synchronizer with rise/fall detect.
// PWM_CAPTURE_GLITCH_FILTER_EN adds a 2-of-3 majority filter.
module pwm_edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic pwm_in,
  output logic s,
  output logic rise,
  output logic fall
);

  logic meta;
  logic sync;
  logic s_q;
  logic s_d;

  // two-flop synchronizer for the asynchronous line
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta <= 1'b0;
      sync <= 1'b0;
    end else begin
      meta <= pwm_in;
      sync <= meta;
    end
  end

`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
  logic h1;
  logic h2;

  // registered majority over the last three synchronized samples
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      h1  <= 1'b0;
      h2  <= 1'b0;
      s_q <= 1'b0;
    end else begin
      h1  <= sync;
      h2  <= h1;
      s_q <= (sync & h1) | (sync & h2) | (h1 & h2);
    end
  end
`else
  assign s_q = sync;
`endif

  // previous sample for edge detection
  always_ff @(posedge clk) begin
    if (!rst_n) s_d <= 1'b0;
    else        s_d <= s_q;
  end

  assign s    = s_q;
  assign rise = s_q & ~s_d;
  assign fall = ~s_q & s_d;

endmodule

// File: rtl/pwm_capture.sv
// PWM capture: high time, period, 3-bit speed, stuck-line watchdog.
// Optional PWM_CAPTURE_GLITCH_FILTER_EN enables input majority filter.
module pwm_capture
  import pwm_pkg::*;
#(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 65535
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             pwm_in,
  output speed_t           speed,
  output logic [CNT_W-1:0] high_time,
  output logic [CNT_W-1:0] period,
  output logic             valid,
  output logic             stuck_hi,
  output logic             stuck_lo
);

  localparam int WIDE = CNT_W + 3;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] TO_M1 = CNT_W'(TIMEOUT - 1);

  function automatic logic [CNT_W-1:0] sat_inc(
    input logic [CNT_W-1:0] v
  );
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

  logic s;
  logic rise;
  logic fall;
  logic edge_seen;

  pwm_edge_sync u_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .pwm_in (pwm_in),
    .s      (s),
    .rise   (rise),
    .fall   (fall)
  );

  assign edge_seen = rise | fall;

  cap_state_t       state;
  cap_state_t       state_n;
  logic [CNT_W-1:0] per_cnt;
  logic [CNT_W-1:0] per_n;
  logic [CNT_W-1:0] hi_cnt;
  logic [CNT_W-1:0] hi_n;
  logic [CNT_W-1:0] stb_cnt;
  logic [CNT_W-1:0] stb_n;
  logic             pub;
  logic             fire;
  speed_t           spd;

  // largest k with 8*high >= k*period, no divider
  always_comb begin
    spd = '0;
    for (int k = 1; k <= 7; k++) begin
      if ({hi_cnt, 3'b000} >= WIDE'(k) * {3'b000, per_cnt})
        spd = speed_t'(k);
    end
  end

  // next state, counters, watchdog and publish strobes
  always_comb begin
    state_n = state;
    per_n   = per_cnt;
    hi_n    = hi_cnt;
    stb_n   = stb_cnt;
    pub     = 1'b0;
    fire    = 1'b0;
    if (!enable) begin
      state_n = IDLE;
      per_n   = '0;
      hi_n    = '0;
      stb_n   = '0;
    end else begin
      if (edge_seen)
        stb_n = '0;
      else if (stb_cnt != TO_VAL)
        stb_n = stb_cnt + 1'b1;
      fire = !edge_seen && (stb_cnt == TO_M1);
      unique case (state)
        IDLE: begin
          if (rise) begin
            per_n   = CNT_W'(1);
            hi_n    = CNT_W'(1);
            state_n = HIGH;
          end
        end
        HIGH: begin
          per_n = sat_inc(per_cnt);
          if (fall) state_n = LOW;
          else      hi_n = sat_inc(hi_cnt);
        end
        LOW: begin
          if (rise) begin
            pub     = 1'b1;
            per_n   = CNT_W'(1);
            hi_n    = CNT_W'(1);
            state_n = HIGH;
          end else begin
            per_n = sat_inc(per_cnt);
          end
        end
        default: state_n = IDLE;
      endcase
      if (fire) state_n = IDLE;
    end
  end

  // FSM state and measurement counters
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      per_cnt <= '0;
      hi_cnt  <= '0;
      stb_cnt <= '0;
    end else begin
      state   <= state_n;
      per_cnt <= per_n;
      hi_cnt  <= hi_n;
      stb_cnt <= stb_n;
    end
  end

  // published results, stuck flags and valid pulse
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      speed     <= '0;
      high_time <= '0;
      period    <= '0;
      valid     <= 1'b0;
      stuck_hi  <= 1'b0;
      stuck_lo  <= 1'b0;
    end else begin
      valid <= pub | fire;
      if (pub) begin
        speed     <= spd;
        high_time <= hi_cnt;
        period    <= per_cnt;
      end
      if (enable && edge_seen) begin
        stuck_hi <= 1'b0;
        stuck_lo <= 1'b0;
      end
      if (fire) begin
        stuck_hi <= s;
        stuck_lo <= ~s;
        speed    <= s ? SPEED_MAX : '0;
      end
    end
  end

endmodule

// File: doc/pwm_capture.md
# pwm_capture

Receive-side counterpart of the team's selectable-speed PWM generator: samples an incoming PWM waveform, measures its high time and period in clock cycles, and reduces the duty cycle to the same 3-bit speed code the generator accepts. Sits behind a dedicated input pin in a Tiny Tapeout–style top and is used for loopback self-test and for decoding PWM from external drivers. It also flags a line stuck high or low.

## Interface
- CNT_W, 16, width of the high-time and period counters and outputs
- TIMEOUT, 65535, cycles without any edge before declaring the line stuck; must be ≤ 2^CNT_W−1 and ≥ 4
- clk  input  1  system clock, all logic on rising edge
- rst_n  input  1  reset, synchronous and active-low
- enable  input  1  capture enable; low forces IDLE and holds all published outputs
- pwm_in  input  1  asynchronous PWM line
- speed  output  3  last decoded speed code, floor(8·high/period) clamped to 7
- high_time  output  CNT_W  last measured high time in cycles
- period  output  CNT_W  last measured period, rising edge to rising edge, in cycles
- valid  output  1  one-cycle pulse when speed/high_time/period or a stuck flag updates
- stuck_hi  output  1  line has been high for TIMEOUT cycles
- stuck_lo  output  1  line has been low for TIMEOUT cycles

## Operation
- pwm_in passes a 2-flop synchronizer; result s, previous s_d; rise = s & ~s_d, fall = ~s & s_d.
- FSM states: IDLE, HIGH, LOW.
- IDLE: wait for rise; on rise load period_cnt=1, high_cnt=1, go HIGH. No publication.
- HIGH: each cycle period_cnt++, high_cnt++; on fall go LOW.
- LOW: each cycle period_cnt++; on rise publish period=period_cnt, high_time=high_cnt, speed, pulse valid, reload counters to 1, go HIGH.
- Speed: largest k in 0..7 with 8·high_cnt ≥ k·period_cnt; comparisons at CNT_W+3 bits, no divider.
- Counters saturate at 2^CNT_W−1; never wrap.
- Edge watchdog stable_cnt: cleared on any rise/fall, else increments (saturating). When it reaches TIMEOUT: stuck_hi=s, stuck_lo=~s, speed = s ? 7 : 0, high_time/period unchanged, valid pulses once, FSM → IDLE. Flags remain until next edge, which clears both in the same cycle the edge is seen.
- enable low: FSM → IDLE, counters and stable_cnt cleared, outputs and flags hold, valid 0. Synchronizer keeps running.
- Simultaneous watchdog expiry and edge cannot occur (edge clears counter first); edge wins.

## Timing
- Reset: speed 0, high_time 0, period 0, valid 0, stuck_hi 0, stuck_lo 0, FSM IDLE, synchronizer flops 0, all counters 0. Reset asserted mid-measurement discards the partial measurement.
- pwm_in edge to rise/fall seen: 2 cycles (4 with filter enabled).
- Closing rise seen to outputs updated and valid high: 1 cycle (registered on the next clk edge).
- First valid after reset or enable needs two rising edges: first full period is published.
- Min measurable: high ≥ 1, low ≥ 1 synchronized cycle; shorter pulses are missed by construction.

## Configuration
- PWM_CAPTURE_GLITCH_FILTER_EN defined: after the synchronizer, a 3-sample majority filter (2-of-3 over last three synchronized samples, registered) drives s; rejects single-cycle glitches; adds 2 cycles of input latency. Measurement results for clean waveforms identical.
- Undefined: s is the synchronizer output directly; single-cycle pulses are measured.

## Structure
- Package pwm_pkg: speed_t (3-bit typedef), capture FSM state enum, SPEED_MAX = 7 constant; shared with the generator.
- Sub-module pwm_edge_sync: synchronizer, optional majority filter, rise/fall outputs. Top holds FSM, counters, speed comparator and watchdog.

## Test plan
- Reset mid-waveform: rst_n low 1 cycle during HIGH → all outputs 0, no valid until two more rising edges.
- Period 16, high 8 (continuous) → valid each 16 cycles, period=16, high_time=8, speed=4.
- Period 16, high 15 → speed=7; period 16, high 1 → speed=0; period 10, high 3 → speed=2.
- TIMEOUT=20, line held high after a valid period → stuck_hi=1, speed=7, one valid pulse 20 cycles after last edge; next fall clears stuck_hi.
- enable dropped mid-period, raised 5 cycles later → no valid during or immediately after; first valid after the second subsequent rise with correct period.
- Filter enabled: 1-cycle low glitch inside a high phase of period 16/high 8 → measurement unchanged (speed 4); filter disabled → a short period is reported.
